// File: rtl/uart_fifo_port_if.sv
// uart_fifo_port_if: CPU data/status slot signals and serial pins of the USB UART.
interface uart_fifo_port_if;
  logic       rd_en;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [1:0] status;
  logic       u_txd;
  logic       u_rxd;
  modport master (output rd_en, wr_en, wr_data, u_txd, input rd_data, status, u_rxd);
  modport slave (input rd_en, wr_en, wr_data, u_txd, output rd_data, status, u_rxd);
endinterface

// File: rtl/uart_fifo_port.sv
// uart_fifo_port: 8N1 UART with RX/TX FIFOs behind the 0xBF02 data / 0xBF03 status slots.
// Define UART_FRAME_CHECK_EN to discard received bytes whose stop bit samples low.
module uart_fifo_port #(
  parameter int CLK_HZ     = 11059200,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  uart_fifo_port_if.slave bus
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [AW:0]   FULL_XOR = {1'b1, {AW{1'b0}}};
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [AW:0]   rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
  logic          rx_empty, rx_full, rx_pop, rx_push, rx_done, rx_end, rx_arm, rx_line;
  logic          tx_empty, tx_full, tx_pop, tx_push;
  logic [1:0]    sy_q;
  state_t        rx_st_q, tx_st_q;
  logic [CW-1:0] rx_cnt_q, tx_cnt_q;
  logic [2:0]    rx_bit_q, tx_bit_q;
  logic [7:0]    rx_sh_q, tx_sh_q;
  logic          txd_q;
  assign rx_empty = rx_wp_q == rx_rp_q;
  assign rx_full  = (rx_wp_q ^ rx_rp_q) == FULL_XOR;
  assign rx_pop   = bus.rd_en && !rx_empty;
  // a pop in the same cycle frees the slot a full FIFO needs for the new byte
  assign rx_push  = rx_done && (!rx_full || rx_pop);
  assign tx_empty = tx_wp_q == tx_rp_q;
  assign tx_full  = (tx_wp_q ^ tx_rp_q) == FULL_XOR;
  assign tx_push  = bus.wr_en && !tx_full;
  assign tx_pop   = !tx_empty && (tx_st_q == IDLE || (tx_st_q == STOP && tx_cnt_q == BIT_END));
  assign bus.rd_data = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q[AW-1:0]];
  assign bus.status  = {!rx_empty, !tx_full};
  assign bus.u_rxd   = txd_q;
  assign rx_line = sy_q[1];
  assign rx_end  = rx_st_q == STOP && rx_cnt_q == BIT_END;
`ifdef UART_FRAME_CHECK_EN
  logic wait_hi_q;
  assign rx_arm  = !rx_line && !wait_hi_q;
  assign rx_done = rx_end && rx_line;
  always_ff @(posedge clk or posedge rst)
    if (rst) wait_hi_q <= 1'b0;
    else if (rx_end && !rx_line) wait_hi_q <= 1'b1;
    else if (rx_line) wait_hi_q <= 1'b0;
`else
  assign rx_arm  = !rx_line;
  assign rx_done = rx_end;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop) rx_rp_q <= rx_rp_q + 1'b1;
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop) tx_rp_q <= tx_rp_q + 1'b1;
    end
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wp_q[AW-1:0]] <= rx_sh_q;
    if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= bus.wr_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sy_q     <= 2'b11;
      rx_st_q  <= IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
    end else begin
      sy_q     <= {sy_q[0], bus.u_txd};
      rx_cnt_q <= rx_cnt_q + 1'b1;
      case (rx_st_q)
        IDLE: begin
          rx_cnt_q <= '0;
          if (rx_arm) rx_st_q <= START;
        end
        START: if (rx_cnt_q == HALF_END) begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          rx_st_q  <= rx_line ? IDLE : DATA;
        end
        DATA: if (rx_cnt_q == BIT_END) begin
          rx_cnt_q <= '0;
          rx_sh_q  <= {rx_line, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_st_q <= STOP;
        end
        default: if (rx_cnt_q == BIT_END) begin
          rx_cnt_q <= '0;
          rx_st_q  <= IDLE;
        end
      endcase
    end
  // STOP hands straight to START when more data waits, so frames run back-to-back
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_st_q  <= IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      txd_q    <= 1'b1;
    end else if (tx_pop) begin
      tx_st_q  <= START;
      tx_cnt_q <= '0;
      tx_sh_q  <= tx_mem_q[tx_rp_q[AW-1:0]];
      txd_q    <= 1'b0;
    end else if (tx_st_q != IDLE) begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
      if (tx_cnt_q == BIT_END) begin
        tx_cnt_q <= '0;
        if (tx_st_q == START) begin
          tx_st_q  <= DATA;
          tx_bit_q <= '0;
          txd_q    <= tx_sh_q[0];
          tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
        end else if (tx_st_q == DATA && tx_bit_q != 3'd7) begin
          tx_bit_q <= tx_bit_q + 1'b1;
          txd_q    <= tx_sh_q[0];
          tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
        end else if (tx_st_q == DATA) begin
          tx_st_q <= STOP;
          txd_q   <= 1'b1;
        end else begin
          tx_st_q <= IDLE;
        end
      end
    end
endmodule

// File: tb/tb_uart_fifo_port.sv
// tb_uart_fifo_port: directed plus randomized bench for uart_fifo_port at DIV=16, using queue models of both FIFOs.
module tb_uart_fifo_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
`ifdef UART_FRAME_CHECK_EN
  localparam bit FRAME_CHK = 1'b1;
`else
  localparam bit FRAME_CHK = 1'b0;
`endif
  uart_fifo_port_if bus();
  uart_fifo_port #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic rx_step(input logic line, input logic rd, input logic push, input logic [7:0] b);
    bus.u_txd = line;
    bus.rd_en = rd;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    if (rd && rxq.size() > 0) void'(rxq.pop_front());
    if (push && rxq.size() < 4) rxq.push_back(b);
    chk("rx_status", {30'd0, rxq.size() != 0, 1'b1}, {30'd0, bus.status});
    chk("rx_data", {24'd0, bus.rd_data}, {24'd0, rxq.size() != 0 ? rxq[0] : 8'h00});
  endtask
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int pop_at);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 160; i++)
      rx_step(f[i/16], i == pop_at, i == 154 && (stop || !FRAME_CHK), b);
  endtask
  task automatic rx_idle(input int n, input int pop_at);
    for (int i = 0; i < n; i++) rx_step(1'b1, i == pop_at, 1'b0, 8'h00);
  endtask
  task automatic cpu_write(input logic [7:0] b);
    bus.wr_en = 1'b1;
    bus.wr_data = b;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask
  task automatic tx_frame_chk(input logic [7:0] b, input bit wait_start, input bit st);
    logic [9:0] f;
    int n;
    f = {1'b1, b, 1'b0};
    if (wait_start) begin
      n = 0;
      while (bus.u_rxd !== 1'b0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("tx_start_timeout", {31'd0, n < 400}, 32'd1);
    end
    for (int i = 0; i < 160; i++) begin
      chk("tx_line", {31'd0, bus.u_rxd}, {31'd0, f[i/16]});
      if (st) chk("tx_not_full", {31'd0, bus.status[0]}, 32'd1);
      @(negedge clk);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] exp4 [4];
    logic [7:0] bs [4];
    int n;
    logic stop;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.u_txd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", {31'd0, bus.u_rxd}, 32'd1);
    rst = 1'b0;
    chk("rst_status", {30'd0, bus.status}, 32'd1);
    chk("rst_data", {24'd0, bus.rd_data}, 32'd0);
    cpu_write(8'hC3);
    repeat (5) @(negedge clk);
    chk("pre_rst_line", {31'd0, bus.u_rxd}, 32'd0);
    #2 rst = 1'b1;
    #1 chk("rst_line_async", {31'd0, bus.u_rxd}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_status", {30'd0, bus.status}, 32'd1);
    chk("post_rst_data", {24'd0, bus.rd_data}, 32'd0);
    repeat (200) begin
      @(negedge clk);
      chk("idle_after_rst", {31'd0, bus.u_rxd}, 32'd1);
    end
    @(posedge clk);
    #1;
    cpu_write(8'hA5);
    tx_frame_chk(8'hA5, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    cpu_write(8'h5A);
    fork
      begin
        tx_frame_chk(8'h5A, 1'b1, 1'b0);
        while (txq.size() > 0) tx_frame_chk(txq.pop_front(), 1'b0, 1'b0);
        repeat (40) begin
          chk("tx_idle_end", {31'd0, bus.u_rxd}, 32'd1);
          @(negedge clk);
        end
      end
      begin
        repeat (30) @(posedge clk);
        #1;
        for (int k = 1; k <= 5; k++) begin
          cpu_write(8'(k));
          if (txq.size() < 4) txq.push_back(8'(k));
          chk("tx_full_flag", {31'd0, bus.status[0]}, {31'd0, txq.size() < 4});
        end
      end
    join
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) bs[k] = 8'($urandom);
      @(posedge clk);
      #1;
      fork
        for (int k = 0; k < n; k++) cpu_write(bs[k]);
        for (int j = 0; j < n; j++) tx_frame_chk(bs[j], j == 0, 1'b0);
      join
    end
    @(posedge clk);
    #1;
    rx_idle(5, -1);
    rx_frame(8'h3C, 1'b1, -1);
    chk("rx_3c_data", {24'd0, bus.rd_data}, 32'h3C);
    rx_idle(3, 0);
    chk("rx_after_pop_status", {30'd0, bus.status}, 32'd1);
    chk("rx_after_pop_data", {24'd0, bus.rd_data}, 32'd0);
    for (int k = 0; k < 5; k++) rx_frame(8'h10 + 8'(k), 1'b1, -1);
    chk("ovf_head", {24'd0, bus.rd_data}, 32'h10);
    rx_frame(8'h15, 1'b1, 154);
    exp4 = '{8'h11, 8'h12, 8'h13, 8'h15};
    for (int k = 0; k < 4; k++) begin
      chk("ovf_drain", {24'd0, bus.rd_data}, {24'd0, exp4[k]});
      rx_step(1'b1, 1'b1, 1'b0, 8'h00);
    end
    chk("ovf_empty", {30'd0, bus.status}, 32'd1);
    rx_frame(8'h77, 1'b0, -1);
    rx_idle(20, -1);
    chk("frame_err_flag", {31'd0, bus.status[1]}, {31'd0, !FRAME_CHK});
    chk("frame_err_data", {24'd0, bus.rd_data}, FRAME_CHK ? 32'd0 : 32'h77);
    rx_idle(2, 0);
    for (int r = 0; r < 8; r++) begin
      stop = $urandom_range(0, 3) != 0;
      n = $urandom_range(0, 2);
      rx_frame(8'($urandom), stop, n == 0 ? -1 : n == 1 ? 154 : int'($urandom_range(0, 159)));
      rx_idle(stop ? int'($urandom_range(0, 8)) : 20, int'($urandom_range(0, 8)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_fifo_port.md
Name: uart_fifo_port

Overview:
- Self-contained 8N1 UART for the USB serial channel, with small RX and TX FIFOs.
- Sits directly downstream of the memory-mapped address decoder:
  - CPU accesses to the serial data slot (0xBF02) reach this block as rd_en / wr_en pulses.
  - The state slot (0xBF03) reads the status output.
- Decouples CPU timing from line timing: bytes are buffered both ways, so the CPU only polls status and never waits on a bit time.

Parameters:
- CLK_HZ, 11059200, system clock frequency in Hz.
- BAUD, 115200, line rate. DIV = CLK_HZ/BAUD cycles per bit; must be ≥ 4.
- FIFO_DEPTH, 4, entries per FIFO. Power of two, 2..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  1-cycle pulse: CPU read of the data slot; pops the RX FIFO head.
- wr_en  in  1  1-cycle pulse: CPU write of the data slot; pushes wr_data into the TX FIFO.
- wr_data  in  8  byte to transmit.
- rd_data  out  8  RX FIFO head (show-ahead); 8'h00 when RX FIFO empty.
- status  out  2  bit0 = TX FIFO not full; bit1 = RX FIFO not empty.
- u_txd  in  1  serial line from host (host TX); idle high.
- u_rxd  out  1  serial line to host (host RX); idle high.

Behaviour:
- Reset: clk and rst as decided above (one clock; rst asynchronous, active-high).
  - Both FIFOs empty; RX and TX FSMs in IDLE; baud counters 0.
  - Outputs: u_rxd = 1, rd_data = 8'h00, status = 2'b01.
  - Reset mid-frame aborts the frame. The TX line returns high in the same cycle rst asserts (async).
- Input sync: u_txd passes through a 2-flop synchroniser, reset value 1. All RX logic uses the synchronised value, so there are 2 cycles of added latency.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronised line = 0.
  - START: wait DIV/2 cycles, resample. If 1 (glitch), return to IDLE. If 0, go to DATA.
  - DATA: sample every DIV cycles, 8 bits, LSB first.
  - STOP: sample after DIV cycles, then push and return to IDLE. Push rules:
    - Byte is pushed to the RX FIFO if not full.
    - If the RX FIFO is full, the new byte is dropped and existing contents are unchanged.
- TX FSM states: IDLE, START, DATA, STOP, each bit held exactly DIV cycles.
  - IDLE -> START when the TX FIFO is non-empty. The head is popped and latched into the shift register on that transition.
  - Line levels: start = 0, then data LSB first, then stop = 1.
  - After STOP, return to IDLE. If the FIFO is non-empty, the next START begins the following cycle, so back-to-back frames have no extra idle.
- FIFO rules (both FIFOs):
  - Circular buffer; pointers are log2(FIFO_DEPTH)+1 bits; wrap-around is handled by the pointer MSB.
  - Push on full is ignored.
  - Pop on empty is ignored, and rd_data stays 8'h00.
  - Simultaneous push and pop:
    - Non-empty and not full: both happen; count unchanged.
    - RX FIFO empty: push only.
    - RX FIFO full, with a byte completing in the same cycle as rd_en: the pop frees the slot and the new byte is stored.
- Timing:
  - status and rd_data are combinational from FIFO state and update the cycle after any push or pop.
  - wr_en while the TX FIFO is full: wr_data is lost; status[0] was already 0.

Optional Feature:
- Macro UART_FRAME_CHECK_EN.
- Defined: RX discards any byte whose stop-bit sample is 0 (framing error); nothing is pushed and the FSM returns to IDLE. RX then waits for the line to return high before detecting a new start bit.
- Undefined: the stop-bit sample is ignored, and every completed frame is pushed.

Test Plan:
- Setup for all cases: CLK_HZ=16, BAUD=1 (DIV=16).
- Reset state: assert rst mid-TX-frame -> u_rxd = 1 immediately; after release, status = 2'b01, rd_data = 8'h00.
- TX single byte: wr_en with wr_data = 8'hA5 ->
  - u_rxd shows 0, 1,0,1,0,0,1,0,1, 1, each bit 16 cycles.
  - status[0] stays 1 throughout.
- TX back-to-back and full:
  - Push 5 bytes 8'h01..8'h05 on consecutive cycles -> 8'h05 ignored; status[0] = 0 after the 4th push.
  - Line carries 01, 02, 03, 04 with no gap between frames.
- RX receive and pop:
  - Drive u_txd with frame 8'h3C -> status[1] = 1 and rd_data = 8'h3C within 2 cycles after stop-bit sampling.
  - rd_en -> status = 2'b01, rd_data = 8'h00.
- RX overflow and simultaneous push/pop:
  - Send 8'h10..8'h14 with no reads -> FIFO holds 10..13.
  - Pulse rd_en in the cycle the 8'h15 frame completes -> FIFO holds 11, 12, 13, 15.
- Framing error: send 8'h77 with stop bit 0 -> with UART_FRAME_CHECK_EN, status[1] stays 0; without it, rd_data = 8'h77.
